// File: rtl/led_matrix_scan.sv
// RGB LED matrix row-scan driver: per-channel PWM, double-buffered frame store.
// Optional anti-ghosting blank phase per row: define LED_SCAN_BLANK_EN.
module led_matrix_scan #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PWM_BITS = 2,
  localparam int RW = $clog2(ROWS),
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PW = 3 * PWM_BITS
) (
  input  logic            kclk,
  input  logic            rst,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [CW-1:0]   wr_col,
  input  logic [PW-1:0]   wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [COLS-1:0] R,
  output logic [COLS-1:0] G,
  output logic [COLS-1:0] B,
  output logic [RW:0]     sele
);

  localparam int NSLOT = (1 << PWM_BITS) - 1;
`ifdef LED_SCAN_BLANK_EN
  localparam int NPH = NSLOT + 1;
`else
  localparam int NPH = NSLOT;
`endif
  localparam logic [PWM_BITS-1:0] PH_FIRST = '0;
  localparam logic [PWM_BITS-1:0] PH_LAST  = PWM_BITS'(NPH - 1);
  localparam logic [RW-1:0]       ROW_LAST = RW'(ROWS - 1);

  logic [PW-1:0]       buf_mem [2][ROWS][COLS];
  logic                front;
  logic [RW-1:0]       row;
  logic [PWM_BITS-1:0] phase;
  logic                at_last;
  logic                wrap;
  logic                wr_ok;
  logic                blank;
  logic [PWM_BITS-1:0] slot;
  logic [COLS-1:0]     r_nxt;
  logic [COLS-1:0]     g_nxt;
  logic [COLS-1:0]     b_nxt;
  logic [PW-1:0]       pix;

  assign at_last = (phase == PH_LAST);
  assign wrap    = at_last && (row == ROW_LAST);
  assign wr_ok   = wr_en && (32'(wr_row) < 32'(ROWS)) && (32'(wr_col) < 32'(COLS));

  // Back buffer is ~front sampled before the edge, so a write on the swap
  // edge lands in the buffer that becomes the new front.
  always_ff @(posedge kclk) begin
    if (wr_ok) buf_mem[~front][wr_row][wr_col] <= wr_data;
  end

  always_ff @(posedge kclk or posedge rst) begin
    if (rst) begin
      row   <= '0;
      phase <= PH_FIRST;
      front <= 1'b0;
    end else begin
      if (at_last) begin
        phase <= PH_FIRST;
        row   <= wrap ? '0 : row + RW'(1);
      end else begin
        phase <= phase + PWM_BITS'(1);
      end
      if (wrap && swap_req) front <= ~front;
    end
  end

`ifdef LED_SCAN_BLANK_EN
  assign blank = (phase == PH_FIRST);
  assign slot  = phase - PWM_BITS'(1);
`else
  assign blank = 1'b0;
  assign slot  = phase;
`endif

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    pix   = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      pix      = buf_mem[front][row][c];
      r_nxt[c] = pix[PW-1 -: PWM_BITS] > slot;
      g_nxt[c] = pix[2*PWM_BITS-1 -: PWM_BITS] > slot;
      b_nxt[c] = pix[PWM_BITS-1:0] > slot;
    end
  end

  always_ff @(posedge kclk or posedge rst) begin
    if (rst) begin
      R           <= '0;
      G           <= '0;
      B           <= '0;
      sele        <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      R           <= (enable && !blank) ? r_nxt : '0;
      G           <= (enable && !blank) ? g_nxt : '0;
      B           <= (enable && !blank) ? b_nxt : '0;
      sele        <= {enable, row};
      swap_ack    <= wrap && swap_req;
      frame_start <= (row == '0) && (phase == PH_FIRST);
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: pixel table plus reset, swap, enable and collision sequences.
`timescale 1ns/1ps
module tb_led_matrix_scan;
`ifdef LED_SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif
  localparam int NSLOT  = 3;
  localparam int T_ROW  = NSLOT + BLANK;
  localparam int FRAME  = 8 * T_ROW;
  localparam int FRAME6 = 6 * T_ROW;

  logic       kclk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [2:0] wr_col = '0;
  logic [5:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start;
  logic [7:0] R, G, B;
  logic [3:0] sele;

  logic       wr6_en = 1'b0;
  logic [2:0] wr6_row = '0;
  logic [2:0] wr6_col = '0;
  logic [5:0] wr6_data = '0;
  logic       swap6_req = 1'b0;
  logic       swap6_ack, fs6;
  logic [5:0] R6, G6, B6;
  logic [3:0] sele6;

  led_matrix_scan #(.ROWS(8), .COLS(8), .PWM_BITS(2)) dut (
    .kclk(kclk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .R(R), .G(G), .B(B), .sele(sele));

  led_matrix_scan #(.ROWS(6), .COLS(6), .PWM_BITS(2)) dut6 (
    .kclk(kclk), .rst(rst), .enable(1'b1), .wr_en(wr6_en), .wr_row(wr6_row),
    .wr_col(wr6_col), .wr_data(wr6_data), .swap_req(swap6_req), .swap_ack(swap6_ack),
    .frame_start(fs6), .R(R6), .G(G6), .B(B6), .sele(sele6));

  always #5 kclk = ~kclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int         row;
    int         col;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    int         er;
    int         eg;
    int         eb;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cr [8][8];
  int   cg [8][8];
  int   cb [8][8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge kclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Starts on a frame_start sample; leaves on the next frame's first sample.
  task automatic observe_main();
    int bad_row = 0;
    int bad_blank = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        cr[r][c] = 0; cg[r][c] = 0; cb[r][c] = 0;
      end
    for (int k = 0; k < FRAME; k++) begin
      int rw = int'(sele[2:0]);
      if (rw != k / T_ROW) bad_row++;
`ifdef LED_SCAN_BLANK_EN
      if (k % T_ROW == 0 && (R | G | B) != 8'h00) bad_blank++;
`endif
      for (int c = 0; c < 8; c++) begin
        cr[rw][c] += int'(R[c]);
        cg[rw][c] += int'(G[c]);
        cb[rw][c] += int'(B[c]);
      end
      tick();
    end
    check("scan_row_sequence", bad_row, 0);
`ifdef LED_SCAN_BLANK_EN
    check("blank_cycles_dark", bad_blank, 0);
`endif
    check("frame_start_period", int'(frame_start), 1);
  endtask

  initial begin
    int n;
    int ackk;
    int bad;
    int bad_msb;
    int sr, sg, sb;

    vecs[0] = '{row:2, col:5, r:2'd2, g:2'd0, b:2'd3, er:2, eg:0, eb:3};
    vecs[1] = '{row:0, col:0, r:2'd3, g:2'd3, b:2'd3, er:3, eg:3, eb:3};
    vecs[2] = '{row:7, col:7, r:2'd1, g:2'd2, b:2'd0, er:1, eg:2, eb:0};
    vecs[3] = '{row:3, col:1, r:2'd0, g:2'd1, b:2'd0, er:0, eg:1, eb:0};
    vecs[4] = '{row:5, col:6, r:2'd3, g:2'd1, b:2'd2, er:3, eg:1, eb:2};

    // Reset, then a second reset asserted mid-frame
    ticks(3);
    rst = 1'b0;
    ticks(13);
    check("pre_reset_sele_msb", int'(sele[3]), 1);
    rst = 1'b1;
    #1;
    check("reset_rgb_zero", int'(|{R, G, B}), 0);
    check("reset_sele", int'(sele), 0);
    check("reset_swap_ack", int'(swap_ack), 0);
    check("reset_frame_start", int'(frame_start), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("first_frame_start", int'(frame_start), 1);
    check("first_sele", int'(sele), 8);
    n = 0;
    do begin tick(); n++; end while (frame_start !== 1'b1 && n < 200);
    check("frame_period_after_reset", n, FRAME);

    // Pixel table into back buffer, then swap requested at cycle 10 of the frame
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_row  = 3'(vecs[i].row);
      wr_col  = 3'(vecs[i].col);
      wr_data = {vecs[i].r, vecs[i].g, vecs[i].b};
      tick();
    end
    wr_en = 1'b0;
    ticks(5);
    swap_req = 1'b1;
    n = 10;
    ackk = -1;
    while (ackk < 0 && n < FRAME + 5) begin
      tick();
      n++;
      if (swap_ack === 1'b1) ackk = n;
    end
    swap_req = 1'b0;
    check("swap_ack_cycle", ackk, FRAME - 1);
    tick();
    check("swap_ack_single_pulse", int'(swap_ack), 0);
    check("frame_start_after_ack", int'(frame_start), 1);
    observe_main();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("vec%0d_R_on_cycles", i), cr[vecs[i].row][vecs[i].col], vecs[i].er);
      check($sformatf("vec%0d_G_on_cycles", i), cg[vecs[i].row][vecs[i].col], vecs[i].eg);
      check($sformatf("vec%0d_B_on_cycles", i), cb[vecs[i].row][vecs[i].col], vecs[i].eb);
    end

    // Display disabled for one frame
    enable = 1'b0;
    bad = 0;
    bad_msb = 0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if ((R | G | B) != 8'h00) bad++;
      if (sele[3] !== 1'b0) bad_msb++;
    end
    check("enable_low_rgb_dark", bad, 0);
    check("enable_low_sele_msb", bad_msb, 0);
    check("enable_low_frame_start", int'(frame_start), 1);
    enable = 1'b1;
    tick();
    check("reenable_sele", int'(sele), 8);
    check("reenable_pixel00_R", int'(R[0]), 1);

    // Write colliding with the swap edge
    wr_en = 1'b1; wr_row = 3'd4; wr_col = 3'd3; wr_data = {2'd0, 2'd3, 2'd0};
    tick();
    wr_en = 1'b0;
    ticks(FRAME - 4);
    wr_en = 1'b1; wr_data = {2'd3, 2'd0, 2'd0}; swap_req = 1'b1;
    tick();
    check("collide_swap_ack", int'(swap_ack), 1);
    wr_en = 1'b0;
    swap_req = 1'b0;
    tick();
    check("collide_frame_start", int'(frame_start), 1);
    observe_main();
    check("collide_R_on_cycles", cr[4][3], NSLOT);
    check("collide_G_on_cycles", cg[4][3], 0);

    // Six-row instance: out-of-range writes are dropped
    n = 0;
    do begin tick(); n++; end while (fs6 !== 1'b1 && n < 200);
    check("dut6_frame_start_seen", int'(fs6), 1);
    for (int r = 0; r < 6; r++) begin
      wr6_en = 1'b1; wr6_row = 3'(r); wr6_col = 3'd1; wr6_data = {2'd1, 2'd0, 2'd0};
      tick();
    end
    wr6_row = 3'd7; wr6_col = 3'd1; wr6_data = 6'h3f; tick();
    wr6_row = 3'd6; wr6_col = 3'd1; wr6_data = 6'h3f; tick();
    wr6_row = 3'd1; wr6_col = 3'd7; wr6_data = 6'h3f; tick();
    wr6_en = 1'b0;
    swap6_req = 1'b1;
    n = 0;
    while (swap6_ack !== 1'b1 && n < 200) begin tick(); n++; end
    swap6_req = 1'b0;
    check("dut6_swap_ack", int'(swap6_ack), 1);
    tick();
    check("dut6_frame_start", int'(fs6), 1);
    sr = 0; sg = 0; sb = 0;
    for (int k = 0; k < FRAME6; k++) begin
      sr += int'(R6[1]);
      sg += int'(G6[1]);
      sb += int'(B6[1]);
      tick();
    end
    check("dut6_col1_R_total", sr, 6);
    check("dut6_col1_G_total", sg, 0);
    check("dut6_col1_B_total", sb, 0);
    check("dut6_frame_period", int'(fs6), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
